score_ctrl: RTL and testbench
=============================

SCORE_CTRL -- requirements
Module: score_ctrl

Interface
REQ-001 SHALL have parameter NDIG, default 3, meaning number of BCD score digits (1..4).
REQ-002 SHALL have parameter SEG_BLANK, default 7'b1111111, meaning the segment pattern for a blanked digit (active-low).
REQ-003 SHALL have port clk  in  1  rising-edge system clock.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  in  1  player start level; only its rising edge is used.
REQ-006 SHALL have port pass  in  1  one-cycle pulse per pipe cleared.
REQ-007 SHALL have port crash  in  1  one-cycle pulse, bird collision.
REQ-008 SHALL have port show_hi  in  1  level; requests the high-score view while in OVER.
REQ-009 SHALL have port hex  out  7*NDIG  active-low segments; digit 0 (ones) in bits [6:0].
REQ-010 SHALL have port running  out  1  high exactly in state PLAY.
REQ-011 SHALL have port saturated  out  1  score held at all-nines.
REQ-012 SHALL have port new_best  out  1  last game set a new high score.

Function
REQ-013 SHALL register start once and detect its rising edge as start & ~start_q.
REQ-014 SHALL implement FSM IDLE, PLAY, OVER: IDLE->PLAY on start edge; PLAY->OVER on crash; OVER->PLAY on start edge; no other transitions.
REQ-015 SHALL clear all score digits, saturated and new_best on every entry to PLAY.
REQ-016 SHALL increment the score by one on the clock edge that samples pass high in PLAY, with hex updated the following cycle (1-cycle latency).
REQ-017 SHALL ripple-carry in BCD: digit 9 with carry-in becomes 0 and carries to the next digit in the same cycle.
REQ-018 SHALL saturate at all-nines (999 for NDIG=3), ignore further pass pulses and hold saturated=1 until the next entry to PLAY.
REQ-019 SHALL count a pass pulse sampled together with crash in PLAY before entering OVER.
REQ-020 SHALL ignore pass and crash in IDLE and OVER; SHALL ignore crash in IDLE.
REQ-021 SHALL freeze the score in OVER.
REQ-022 SHALL blank leading zero digits, except that digit 0 is always shown.
REQ-023 SHALL display 0 (7'b1000000 on digit 0) in IDLE.

Reset
REQ-024 SHALL on reset enter IDLE and clear score, high score, start_q, running, saturated and new_best; after reset hex SHALL show "0" with the upper digits blanked.
REQ-025 SHALL give reset priority over every other input, including mid-increment and mid-carry.

Configuration
REQ-026 SHALL, with SCORE_HISCORE_EN defined, keep a BCD high score updated on PLAY->OVER when score > high (strictly greater), set new_best=1 in that case, and show the high score on hex while in OVER and show_hi=1.
REQ-027 SHALL, without SCORE_HISCORE_EN, omit all high-score storage, tie new_best to 0 and ignore show_hi.

Structure
REQ-028 SHALL put the state enum, the BCD digit typedef, the segment constants for 0-9 and the bcd-to-segment function in package score_pkg.
REQ-029 SHALL instantiate NDIG copies of sub-module bcd_digit (a decade counter with clear, carry-in and carry-out).

Verification
REQ-030 SHALL cover: reset, start edge, 12 pass pulses -> hex shows "12" with digit 2 blanked; running=1.
REQ-031 SHALL cover: score 9, then pass -> "10" the next cycle; score 99, then pass -> "100".
REQ-032 SHALL cover: score 999, then 3 passes -> still "999"; saturated=1; restart clears it.
REQ-033 SHALL cover: pass and crash in the same cycle at score 4 -> OVER with "5"; later passes ignored.
REQ-034 SHALL cover, with SCORE_HISCORE_EN: game scores 7, then game scores 3 -> high score 7; show_hi=1 shows "7"; new_best=0 after the second game.
REQ-035 SHALL cover: reset asserted in PLAY at score 42 -> next cycle IDLE, "0", running=0.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types and seven-segment helpers for the score controller.
package score_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_OVER = 2'd2
   } state_t;

   typedef logic [3:0] bcd_t;

   // Active-low segments, bit order gfedcba.
   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;

   function automatic logic [6:0] bcd_to_seg(input bcd_t d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/score_ctrl_bcd_digit.sv
// One decade of the score: BCD counter with synchronous clear, carry-in and carry-out.
module bcd_digit
   import score_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   input  logic i_cin,
   output bcd_t o_q,
   output bcd_t o_q_nxt,
   output logic o_cout
);

   bcd_t r_q;
   bcd_t w_q_nxt;

   // Next value; exposed so the parent can register the display in the same edge.
   always_comb begin
      w_q_nxt = r_q;
      if (i_clr) begin
         w_q_nxt = 4'd0;
      end else if (i_cin) begin
         if (r_q == 4'd9) begin
            w_q_nxt = 4'd0;
         end else begin
            w_q_nxt = r_q + 4'd1;
         end
      end else begin
         w_q_nxt = r_q;
      end
   end

   // Digit register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_q <= 4'd0;
      end else begin
         r_q <= w_q_nxt;
      end
   end

   assign o_q     = r_q;
   assign o_q_nxt = w_q_nxt;
   assign o_cout  = i_cin & ~i_clr & (r_q == 4'd9);

endmodule

// File: rtl/score_ctrl.sv
// Game score controller: IDLE/PLAY/OVER FSM, saturating BCD score, 7-seg display.
// Optional high-score tracking and view enabled by defining SCORE_HISCORE_EN.
module score_ctrl
   import score_pkg::*;
#(
   parameter int         NDIG      = 3,
   parameter logic [6:0] SEG_BLANK = 7'b1111111
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              pass,
   input  logic              crash,
   input  logic              show_hi,
   output logic [7*NDIG-1:0] hex,
   output logic              running,
   output logic              saturated,
   output logic              new_best
);

   localparam logic [7*NDIG-1:0] HEX_BLANK = {NDIG{SEG_BLANK}};
   localparam logic [7*NDIG-1:0] HEX_ZERO  =
      (HEX_BLANK & ~((7*NDIG)'(7'h7f))) | (7*NDIG)'(SEG_0);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_start_q;
   logic              r_running;
   logic              r_saturated;
   logic [7*NDIG-1:0] r_hex;
   logic [7*NDIG-1:0] w_hex_nxt;
   logic              w_start_edge;
   logic              w_enter_play;
   logic              w_inc;
   logic              w_all9_cur;
   logic              w_all9_nxt;
   logic              w_lead;
   logic [NDIG:0]     w_carry;
   logic [4*NDIG-1:0] w_score;
   logic [4*NDIG-1:0] w_score_nxt;
   logic [4*NDIG-1:0] w_disp_val;
   logic [4*NDIG-1:0] w_val;
   logic              w_unused_carry;

   assign w_start_edge   = start & ~r_start_q;
   assign w_enter_play   = w_start_edge & (r_state != ST_PLAY);
   assign w_inc          = (r_state == ST_PLAY) & pass & ~w_all9_cur;
   assign w_carry[0]     = w_inc;
   assign w_unused_carry = w_carry[NDIG];

   genvar gi;
   generate
      for (gi = 0; gi < NDIG; gi++) begin : g_dig
         bcd_digit u_dig (
            .clk     (clk),
            .reset   (reset),
            .i_clr   (w_enter_play),
            .i_cin   (w_carry[gi]),
            .o_q     (w_score[4*gi +: 4]),
            .o_q_nxt (w_score_nxt[4*gi +: 4]),
            .o_cout  (w_carry[gi+1])
         );
      end
   endgenerate

   // All-nines detection on the current and the upcoming score.
   always_comb begin
      w_all9_cur = 1'b1;
      w_all9_nxt = 1'b1;
      for (int k = 0; k < NDIG; k++) begin
         w_all9_cur = w_all9_cur & (w_score[4*k +: 4] == 4'd9);
         w_all9_nxt = w_all9_nxt & (w_score_nxt[4*k +: 4] == 4'd9);
      end
   end

   // FSM next state.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_start_edge) w_state_nxt = ST_PLAY;
            else              w_state_nxt = ST_IDLE;
         end
         ST_PLAY: begin
            if (crash) w_state_nxt = ST_OVER;
            else       w_state_nxt = ST_PLAY;
         end
         ST_OVER: begin
            if (w_start_edge) w_state_nxt = ST_PLAY;
            else              w_state_nxt = ST_OVER;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

`ifdef SCORE_HISCORE_EN
   logic [4*NDIG-1:0] r_hi;
   logic [4*NDIG-1:0] w_hi_nxt;
   logic              r_new_best;
   logic              w_beat;

   // Compare against the score including a pass sampled with the crash.
   assign w_beat     = (r_state == ST_PLAY) & crash & (w_score_nxt > r_hi);
   assign w_hi_nxt   = w_beat ? w_score_nxt : r_hi;
   assign w_disp_val = (show_hi && (w_state_nxt == ST_OVER)) ? w_hi_nxt : w_score_nxt;
   assign new_best   = r_new_best;

   // High score and new-best flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hi       <= {(4*NDIG){1'b0}};
         r_new_best <= 1'b0;
      end else begin
         r_hi <= w_hi_nxt;
         if (w_enter_play) r_new_best <= 1'b0;
         else if (w_beat)  r_new_best <= 1'b1;
         else              r_new_best <= r_new_best;
      end
   end
`else
   logic w_unused_show;
   assign w_unused_show = show_hi;
   assign w_disp_val    = w_score_nxt;
   assign new_best      = 1'b0;
`endif

   // Display image for the next cycle with leading-zero blanking.
   always_comb begin
      w_val     = (w_state_nxt == ST_IDLE) ? {(4*NDIG){1'b0}} : w_disp_val;
      w_lead    = 1'b1;
      w_hex_nxt = HEX_BLANK;
      for (int k = NDIG - 1; k >= 0; k--) begin
         if ((k != 0) && w_lead && (w_val[4*k +: 4] == 4'd0)) begin
            w_hex_nxt[7*k +: 7] = SEG_BLANK;
         end else begin
            w_hex_nxt[7*k +: 7] = bcd_to_seg(w_val[4*k +: 4]);
            w_lead = 1'b0;
         end
      end
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_start_q   <= 1'b0;
         r_running   <= 1'b0;
         r_saturated <= 1'b0;
         r_hex       <= HEX_ZERO;
      end else begin
         r_state     <= w_state_nxt;
         r_start_q   <= start;
         r_running   <= (w_state_nxt == ST_PLAY);
         r_saturated <= w_all9_nxt;
         r_hex       <= w_hex_nxt;
      end
   end

   assign hex       = r_hex;
   assign running   = r_running;
   assign saturated = r_saturated;

endmodule

// File: tb/tb_score_ctrl.sv
// Self-checking bench for score_ctrl: vector table, directed corner sequences, random vs. model.
module tb_score_ctrl;

   localparam int NDIG = 3;
   localparam int MAXV = 999;
`ifdef SCORE_HISCORE_EN
   localparam bit HI_EN = 1'b1;
`else
   localparam bit HI_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, start, pass, crash, show_hi;
   logic [20:0] hex;
   logic        running, saturated, new_best;

   int n_chk = 0;
   int n_err = 0;

   // model state: 0 idle, 1 play, 2 over
   int m_st, m_score, m_hi, m_startq, m_show;
   bit m_sat, m_nb;

   always #5 clk = ~clk;

   score_ctrl #(.NDIG(NDIG)) dut (
      .clk(clk), .reset(reset), .start(start), .pass(pass), .crash(crash),
      .show_hi(show_hi), .hex(hex), .running(running), .saturated(saturated),
      .new_best(new_best)
   );

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b1000000;  1: return 7'b1111001;
         2: return 7'b0100100;  3: return 7'b0110000;
         4: return 7'b0011001;  5: return 7'b0010010;
         6: return 7'b0000010;  7: return 7'b1111000;
         8: return 7'b0000000;  9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [20:0] hex_of(input int v);
      logic [20:0] h;
      int p;
      p = 1;
      for (int k = 0; k < NDIG; k++) begin
         if (k > 0 && v < p) h[7*k +: 7] = 7'b1111111;
         else                h[7*k +: 7] = seg_of((v / p) % 10);
         p = p * 10;
      end
      return h;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit s, input bit p, input bit c, input bit h);
      bit edge_s;
      m_show = h;
      if (r) begin
         m_st = 0; m_score = 0; m_hi = 0; m_startq = 0; m_sat = 0; m_nb = 0;
      end else begin
         edge_s = s && (m_startq == 0);
         m_startq = s;
         if (m_st == 1) begin
            if (p && m_score < MAXV) m_score = m_score + 1;
            m_sat = (m_score == MAXV);
            if (c) begin
               m_st = 2;
               if (HI_EN && m_score > m_hi) begin
                  m_hi = m_score;
                  m_nb = 1;
               end
            end
         end else if (edge_s) begin
            m_st = 1; m_score = 0; m_sat = 0; m_nb = 0;
         end
      end
   endtask

   function automatic int model_disp();
      if (m_st == 0) return 0;
      if (HI_EN && m_st == 2 && m_show != 0) return m_hi;
      return m_score;
   endfunction

   task automatic cyc(input bit r, input bit s, input bit p, input bit c, input bit h);
      reset = r; start = s; pass = p; crash = c; show_hi = h;
      model_step(r, s, p, c, h);
      @(posedge clk);
      #1;
      chk("hex", hex, hex_of(model_disp()));
      chk("running", running, m_st == 1);
      chk("saturated", saturated, m_sat);
      chk("new_best", new_best, m_nb);
   endtask

   task automatic passes(input int n);
      for (int i = 0; i < n; i++) cyc(0, 1, 1, 0, 0);
   endtask

   // leave any game, then produce a fresh start edge
   task automatic new_game();
      cyc(0, 1, 0, 1, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
   endtask

   typedef struct {
      bit r, s, p, c;
      int val;
      bit run;
   } vec_t;

   vec_t tbl[12];

   initial begin
      reset = 1'b1; start = 1'b0; pass = 1'b0; crash = 1'b0; show_hi = 1'b0;
      m_st = 0; m_score = 0; m_hi = 0; m_startq = 0; m_show = 0; m_sat = 0; m_nb = 0;

      tbl[0]  = '{1, 0, 0, 0, 0, 0};
      tbl[1]  = '{0, 1, 0, 0, 0, 1};
      tbl[2]  = '{0, 1, 1, 0, 1, 1};
      tbl[3]  = '{0, 0, 1, 0, 2, 1};
      tbl[4]  = '{0, 0, 0, 0, 2, 1};
      tbl[5]  = '{0, 0, 1, 1, 3, 0};
      tbl[6]  = '{0, 0, 1, 0, 3, 0};
      tbl[7]  = '{0, 1, 0, 0, 0, 1};
      tbl[8]  = '{0, 1, 1, 0, 1, 1};
      tbl[9]  = '{1, 1, 1, 0, 0, 0};
      tbl[10] = '{0, 1, 0, 0, 0, 1};
      tbl[11] = '{0, 1, 0, 1, 0, 0};

      // reset state
      cyc(1, 0, 0, 0, 0);
      chk("rst_hex", hex, 32'h001FFFC0);
      chk("rst_running", running, 1'b0);

      for (int i = 0; i < 12; i++) begin
         cyc(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].c, 1'b0);
         chk($sformatf("tbl%0d_hex", i), hex, hex_of(tbl[i].val));
         chk($sformatf("tbl%0d_run", i), running, tbl[i].run);
      end

      // twelve passes
      cyc(1, 0, 0, 0, 0);
      new_game();
      passes(12);
      chk("twelve_hex", hex, {7'b1111111, 7'b1111001, 7'b0100100});
      chk("twelve_run", running, 1'b1);

      // carries 9->10 and 99->100
      new_game();
      passes(9);
      passes(1);
      chk("carry10", hex, {7'b1111111, 7'b1111001, 7'b1000000});
      passes(89);
      passes(1);
      chk("carry100", hex, {7'b1111001, 7'b1000000, 7'b1000000});

      // saturation at 999, then restart clears it
      passes(899);
      chk("reach999_sat", saturated, 1'b1);
      passes(3);
      chk("hold999", hex, {7'b0010000, 7'b0010000, 7'b0010000});
      chk("hold999_sat", saturated, 1'b1);
      new_game();
      chk("restart_sat", saturated, 1'b0);
      chk("restart_hex", hex, hex_of(0));

      // pass together with crash at 4
      new_game();
      passes(4);
      cyc(0, 1, 1, 1, 0);
      chk("pc_hex", hex, hex_of(5));
      chk("pc_run", running, 1'b0);
      passes(3);
      chk("pc_frozen", hex, hex_of(5));

`ifdef SCORE_HISCORE_EN
      cyc(1, 0, 0, 0, 0);
      new_game();
      passes(7);
      cyc(0, 1, 0, 1, 0);
      chk("hi_nb1", new_best, 1'b1);
      new_game();
      chk("hi_nb_clr", new_best, 1'b0);
      passes(3);
      cyc(0, 1, 0, 1, 0);
      chk("hi_nb2", new_best, 1'b0);
      chk("hi_score3", hex, hex_of(3));
      cyc(0, 1, 0, 0, 1);
      chk("hi_show7", hex, hex_of(7));
      cyc(0, 1, 0, 0, 0);
      chk("hi_unshow", hex, hex_of(3));
`endif

      // reset in the middle of a game at 42
      cyc(1, 0, 0, 0, 0);
      new_game();
      passes(42);
      chk("s42", hex, hex_of(42));
      cyc(1, 1, 1, 0, 0);
      chk("rst42_hex", hex, hex_of(0));
      chk("rst42_run", running, 1'b0);

      // random traffic against the model
      begin
         bit rs, ss, ps, cs, hs;
         ss = 1'b0;
         for (int i = 0; i < 4000; i++) begin
            rs = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) ss = ~ss;
            ps = ($urandom_range(0, 2) != 0);
            cs = ($urandom_range(0, 59) == 0);
            hs = $urandom_range(0, 1);
            cyc(rs, ss, ps, cs, hs);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
